// File: rtl/chaos_key_tx_pkg.sv
// Shared constants for the chaos key transmit port: register map, bit positions, widths.
// The optional overflow event is enabled by defining CHAOS_KEY_TX_OVERFLOW_EN.
package chaos_key_tx_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_EVENT  = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 7;

    localparam int EVT_DRAINED_BIT  = 0;
    localparam int EVT_OVERFLOW_BIT = 1;
    localparam int EVT_W            = 2;

    function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                                input logic [STAT_COUNT_W-1:0] count);
        logic [31:0] word;
        word = '0;
        word[STAT_EMPTY_BIT] = empty;
        word[STAT_FULL_BIT]  = full;
        word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/chaos_key_tx_fifo.sv
// Synchronous byte FIFO; push/pop must already be qualified by the caller (no push at
// full, no pop at empty). Head is read straight from storage, so there is no fall-through.
module chaos_key_tx_fifo
    import chaos_key_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;

    // Storage is left unreset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/chaos_key_tx_port.sv
// Avalon-MM slave that queues key bytes into a FIFO and streams them to hardware.
// Define CHAOS_KEY_TX_OVERFLOW_EN to record rejected pushes in event bit1.
module chaos_key_tx_port
    import chaos_key_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef CHAOS_KEY_TX_OVERFLOW_EN
    localparam logic [EVT_W-1:0] EVT_IMPL = 2'b11;
`else
    localparam logic [EVT_W-1:0] EVT_IMPL = 2'b01;
`endif

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;

    logic [31:0]       readdata_reg;
    logic [31:0]       readdata_next;
    logic [DATA_W-1:0] last_byte_reg;
    logic [EVT_W-1:0]  irq_mask_reg;
    logic [EVT_W-1:0]  event_reg;
    logic [EVT_W-1:0]  event_next;
    logic [EVT_W-1:0]  event_set;

    logic bus_write;
    logic push_req;
    logic push_ok;
    logic pop_ok;
    logic event_clear;

    wire unused_writedata = &{1'b0, writedata[31:8]};

    assign bus_write   = chipselect && !write_n;
    assign push_req    = bus_write && (address == ADDR_DATA);
    assign push_ok     = push_req && !fifo_full;
    assign pop_ok      = out_valid && out_ready;
    assign event_clear = bus_write && (address == ADDR_EVENT);

    chaos_key_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (writedata[DATA_W-1:0]),
        .pop       (pop_ok),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;

    // Drain fires only when the queue really goes empty, not when a refill coincides.
    assign event_set[EVT_DRAINED_BIT] = pop_ok && (fifo_count == CNT_W'(1)) && !push_ok;
`ifdef CHAOS_KEY_TX_OVERFLOW_EN
    assign event_set[EVT_OVERFLOW_BIT] = push_req && fifo_full;
`else
    assign event_set[EVT_OVERFLOW_BIT] = 1'b0;
`endif

    // A clear write beats any set in the same cycle.
    generate
        for (genvar gi = 0; gi < EVT_W; gi++) begin : g_event
            always_comb begin
                event_next[gi] = event_reg[gi];
                if (event_clear) begin
                    event_next[gi] = 1'b0;
                end else if (event_set[gi]) begin
                    event_next[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:   readdata_next[DATA_W-1:0] = last_byte_reg;
            ADDR_STATUS: readdata_next = pack_status(fifo_empty, fifo_full,
                                                     STAT_COUNT_W'(fifo_count));
            ADDR_MASK:   readdata_next[EVT_W-1:0] = irq_mask_reg;
            default:     readdata_next[EVT_W-1:0] = event_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg  <= '0;
            last_byte_reg <= '0;
            irq_mask_reg  <= '0;
            event_reg     <= '0;
        end else begin
            readdata_reg <= readdata_next;
            event_reg    <= event_next & EVT_IMPL;
            if (pop_ok) begin
                last_byte_reg <= fifo_head;
            end
            if (bus_write && (address == ADDR_MASK)) begin
                irq_mask_reg <= writedata[EVT_W-1:0] & EVT_IMPL;
            end
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(event_reg & irq_mask_reg);

endmodule

// File: tb/tb_chaos_key_tx_port.sv
// Directed bench for chaos_key_tx_port: register map, streaming, events, irq and reset.
// Overflow expectations follow CHAOS_KEY_TX_OVERFLOW_EN when it is defined for the build.
module tb_chaos_key_tx_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

`ifdef CHAOS_KEY_TX_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    chaos_key_tx_port #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        d = readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata got 0x%08h want 0", readdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL reset_status got 0x%08h want 0x00000001", rd); end
        bus_read(2'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_mask got 0x%08h want 0", rd); end
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_event got 0x%08h want 0", rd); end
    endtask

    task automatic test_single_byte();
        logic [31:0] rd;
        out_ready = 1'b1;
        bus_write(2'd0, 32'h0000_00A5);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            miscompares++; $display("FAIL single_head got v=%b d=0x%02h want v=1 d=0xa5", out_valid, out_data);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle got v=%b want 0", out_valid); end
        bus_read(2'd0, rd);
        vectors++;
        if (rd !== 32'h0000_00A5) begin miscompares++; $display("FAIL single_last_byte got 0x%08h want 0x000000a5", rd); end
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL single_drained got 0x%08h want 0x00000001", rd); end
        bus_write(2'd3, 32'h0);
        out_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        logic [31:0] rd;
        for (int i = 1; i <= 8; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0802) begin miscompares++; $display("FAIL full_status got 0x%08h want 0x00000802", rd); end
        bus_write(2'd0, 32'h0000_00FF);
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== (OVF_EN ? 32'h2 : 32'h0)) begin
            miscompares++; $display("FAIL overflow_event got 0x%08h want 0x%08h", rd, OVF_EN ? 32'h2 : 32'h0);
        end
        bus_write(2'd2, 32'h0000_0002);
        bus_read(2'd2, rd);
        vectors++;
        if (rd !== (OVF_EN ? 32'h2 : 32'h0)) begin
            miscompares++; $display("FAIL overflow_mask got 0x%08h want 0x%08h", rd, OVF_EN ? 32'h2 : 32'h0);
        end
        vectors++;
        if (irq !== OVF_EN) begin miscompares++; $display("FAIL overflow_irq got %b want %b", irq, OVF_EN); end
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0802) begin miscompares++; $display("FAIL overflow_status got 0x%08h want 0x00000802", rd); end
    endtask

    task automatic test_drain();
        logic [31:0] rd;
        bus_write(2'd3, 32'h0);
        bus_write(2'd2, 32'h0000_0001);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL drain_irq_before got %b want 0", irq); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                miscompares++; $display("FAIL drain_byte%0d got v=%b d=0x%02h want v=1 d=0x%02h", i, out_valid, out_data, i);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got v=%b want 0", out_valid); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL drain_irq got %b want 1", irq); end
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL drain_event got 0x%08h want 0x00000001", rd); end
        bus_read(2'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0008) begin miscompares++; $display("FAIL drain_last_byte got 0x%08h want 0x00000008", rd); end
    endtask

    task automatic test_clear_vs_drain();
        logic [31:0] rd;
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h0000_0033);
        out_ready = 1'b1;
        bus_write(2'd3, 32'h0);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clear_pop got v=%b want 0", out_valid); end
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL clear_wins got 0x%08h want 0", rd); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL clear_irq got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(2'd0, 32'h0000_0010);
        out_ready = 1'b1;
        bus_write(2'd0, 32'h0000_0020);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h20) begin
            miscompares++; $display("FAIL b2b_head got v=%b d=0x%02h want v=1 d=0x20", out_valid, out_data);
        end
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0100) begin miscompares++; $display("FAIL b2b_status got 0x%08h want 0x00000100", rd); end
        bus_read(2'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0010) begin miscompares++; $display("FAIL b2b_last_byte got 0x%08h want 0x00000010", rd); end
        bus_read(2'd3, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL b2b_no_drain got 0x%08h want 0", rd); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] rd;
        bus_write(2'd0, 32'h0000_0041);
        bus_write(2'd0, 32'h0000_0042);
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0300) begin miscompares++; $display("FAIL midrst_status_before got 0x%08h want 0x00000300", rd); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            miscompares++; $display("FAIL midrst_outputs got v=%b irq=%b want 0 0", out_valid, irq);
        end
        vectors++;
        if (readdata !== 32'h0) begin miscompares++; $display("FAIL midrst_readdata got 0x%08h want 0", readdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL midrst_status_after got 0x%08h want 0x00000001", rd); end
        bus_read(2'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL midrst_mask got 0x%08h want 0", rd); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_drain();
        test_clear_vs_drain();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chaos_key_tx_port.md
CHAOS_KEY_TX_PORT -- requirements
Module: chaos_key_tx_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning byte FIFO depth (power of 2, 4..64).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon-MM slave word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.
- out_data  out  8  key byte to hardware.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  hardware accepts the byte.

Function
REQ-003 Register map SHALL be:
- 0: write pushes writedata[7:0]; read returns the last byte transferred.
- 1: read-only status. bit0 empty, bit1 full, bits[14:8] count.
- 2: irq_mask R/W bits[1:0].
- 3: event R/W. bit0 drained, bit1 overflow; any write clears both bits.
REQ-004 readdata SHALL update every cycle from address regardless of chipselect (one-cycle read latency), with unused bits 0.
REQ-005 A push SHALL occur on chipselect && !write_n && address==0 && !full, evaluated on the pre-edge count.
REQ-006 out_valid SHALL equal !empty, and out_data SHALL equal the FIFO head.
REQ-007 A pop SHALL occur when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-008 A push into an empty FIFO SHALL raise out_valid the cycle after the write edge; there is no fall-through.
REQ-009 A simultaneous push and pop SHALL leave count unchanged and preserve byte order.
REQ-010 A push at full SHALL be rejected even if a pop occurs in the same cycle.
REQ-011 Event bit0 SHALL set when a pop takes count from 1 to 0 with no simultaneous push.
REQ-012 An event-register clear write SHALL win over a same-cycle event set.
REQ-013 irq SHALL be the OR of (event & irq_mask).
REQ-014 Pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL range 0..FIFO_DEPTH.

Reset
REQ-015 When reset_n is low, the following SHALL clear asynchronously: FIFO (count 0), readdata, last-byte register, irq_mask and event.
REQ-016 Consequently out_valid=0 and irq=0 during reset; reset mid-transfer SHALL discard queued bytes.

Configuration
REQ-017 With CHAOS_KEY_TX_OVERFLOW_EN defined, a rejected push SHALL set event bit1.
REQ-018 Without CHAOS_KEY_TX_OVERFLOW_EN, a rejected push SHALL be silently dropped; event bit1 and irq_mask bit1 SHALL read 0 and ignore writes.

Structure
REQ-019 Package chaos_key_tx_pkg SHALL hold:
- register address constants;
- status and event bit positions;
- the data width constant (8).
REQ-020 Sub-module chaos_key_tx_fifo SHALL be a synchronous FIFO providing push, pop, head, count, empty and full; register logic SHALL stay in the top.

Verification
REQ-021 Directed scenarios:
- Write 0xA5 to addr0 with out_ready=1: out_valid=1 for exactly one cycle with out_data=0xA5; addr0 then reads 0xA5.
- out_ready=0, push 0x01..0x08 (depth 8): status reads 0x0802; a 9th write of 0xFF with OVERFLOW_EN sets event=0x2, and irq=1 once mask=0x2.
- From full, release out_ready: bytes 0x01..0x08 emerge in order; event bit0 sets after the last; irq follows mask bit0.
- Clear event write coinciding with the drain pop: event reads 0.
- Assert reset_n=0 with 3 bytes queued: out_valid=0 immediately, status=0x0001 after release.
- Overflow push without OVERFLOW_EN: event stays 0x0; FIFO contents unchanged.
